// File: rtl/spi_ram_burst.sv
// SPI-side RAM with independent read/write pointers, optional auto-increment
// and multi-word read bursts handed to the serializer over a valid/ready handshake.
//   state | meaning
//   IDLE  | accepting commands, no word offered to the serializer
//   SEND  | burst in progress, dout offered, incoming commands dropped
module spi_ram_burst #(
    parameter int ADDR_SIZE = 8,
    parameter int WORD_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 drop_err
);

    localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_nxt;
    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [WORD_SIZE-1:0] cnt;
    logic [1:0]           opcode;
    logic [WORD_SIZE-1:0] payload;
    logic                 accept, handshake, last;

    assign opcode     = din[WORD_SIZE+1:WORD_SIZE];
    assign payload    = din[WORD_SIZE-1:0];
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign last       = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        handshake = 1'b0;
        busy      = 1'b0;
        tx_valid  = 1'b0;
        case (state)
            IDLE: begin
                accept = rx_valid;
                if (accept && opcode == OP_RD_DATA) state_nxt = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                tx_valid  = 1'b1;
                handshake = tx_ready;
                if (handshake && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && opcode == OP_WR_DATA) mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            dout     <= '0;
            drop_err <= 1'b0;
        end else begin
            if (rx_valid && busy) drop_err <= 1'b1;
            if (accept) begin
                case (opcode)
                    OP_WR_ADDR: wr_ptr <= payload[ADDR_SIZE-1:0];
                    OP_WR_DATA: if (AUTO_INC) wr_ptr <= wr_ptr + 1'b1;
                    OP_RD_ADDR: rd_ptr <= payload[ADDR_SIZE-1:0];
                    OP_RD_DATA: begin
                        dout <= mem[rd_ptr];
                        cnt  <= payload;
                    end
                    default: ;
                endcase
            end
            if (handshake) begin
                if (AUTO_INC) rd_ptr <= rd_ptr_inc;
                if (!last) begin
                    cnt  <= cnt - 1'b1;
                    dout <= AUTO_INC ? mem[rd_ptr_inc] : mem[rd_ptr];
                end
            end
        end
    end

endmodule
